// File: rtl/align_rmw_ramwrap.sv
// Narrow logical words packed NUMWRDS per wide SRAM row. Partial-row writes run as read-modify-write.
// Optional single-entry row cache, enabled by defining ALIGN_ROWCACHE_EN.
module align_rmw_ramwrap #(
    parameter int WIDTH      = 32,
    parameter int NUMADDR    = 1024,
    parameter int BITADDR    = 10,
    parameter int NUMWRDS    = 4,
    parameter int BITWRDS    = 2,
    parameter int NUMSROW    = 256,
    parameter int BITSROW    = 8,
    parameter int SRAM_DELAY = 2,
    parameter int FLOPOUT    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic                       write,
    input  logic [BITADDR-1:0]         wr_adr,
    input  logic [WIDTH-1:0]           bw,
    input  logic [WIDTH-1:0]           din,
    input  logic                       read,
    input  logic [BITADDR-1:0]         rd_adr,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dout,
    output logic                       mem_write,
    output logic [BITSROW-1:0]         mem_wr_adr,
    output logic [NUMWRDS*WIDTH-1:0]   mem_din,
    output logic                       mem_read,
    output logic [BITSROW-1:0]         mem_rd_adr,
    input  logic [NUMWRDS*WIDTH-1:0]   mem_rd_dout
);
    localparam int WSW = (BITWRDS > 0) ? BITWRDS : 1;
    localparam int RW  = NUMWRDS * WIDTH;
    localparam int CW  = (SRAM_DELAY > 2) ? $clog2(SRAM_DELAY - 1) : 1;

    if (NUMSROW * NUMWRDS < NUMADDR || SRAM_DELAY < 1) begin : g_bad_cfg
        $error("align_rmw_ramwrap: invalid geometry or SRAM_DELAY");
    end

    function automatic logic [BITSROW-1:0] row_of(input logic [BITADDR-1:0] adr);
        return BITSROW'(32'(adr) / NUMWRDS);
    endfunction

    function automatic logic [WSW-1:0] word_of(input logic [BITADDR-1:0] adr);
        return WSW'(32'(adr) % NUMWRDS);
    endfunction

    function automatic logic in_range(input logic [BITADDR-1:0] adr);
        return 32'(adr) < NUMADDR;
    endfunction

    function automatic logic [RW-1:0] merge(input logic [RW-1:0] old, input logic [WSW-1:0] w,
                                            input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] d);
        logic [RW-1:0] r;
        r = old;
        for (int i = 0; i < NUMWRDS; i++)
            if (32'(w) == i) r[i*WIDTH +: WIDTH] = (old[i*WIDTH +: WIDTH] & ~m) | (d & m);
        return r;
    endfunction

    logic wr_acc, rd_acc, wr_ok, rd_ok, wr_hit, wr_rmw;
    logic [RW-1:0] hit_din;

    assign wr_acc = write && ready && !rst;
    assign rd_acc = read && ready && !write && !rst;
    assign wr_ok  = wr_acc && in_range(wr_adr);
    assign rd_ok  = rd_acc && in_range(rd_adr);
    assign wr_rmw = wr_ok && !wr_hit;

`ifdef ALIGN_ROWCACHE_EN
    logic               cache_vld;
    logic [BITSROW-1:0] cache_row;
    logic [RW-1:0]      cache_data;

    assign wr_hit  = wr_ok && cache_vld && (cache_row == row_of(wr_adr));
    assign hit_din = merge(cache_data, word_of(wr_adr), bw, din);

    // Every row write leaves the cache holding exactly what the SRAM now holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld  <= 1'b0;
            cache_row  <= '0;
            cache_data <= '0;
        end else if (mem_write) begin
            cache_vld  <= 1'b1;
            cache_row  <= mem_wr_adr;
            cache_data <= mem_din;
        end
    end
`else
    assign wr_hit  = 1'b0;
    assign hit_din = '0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;
    state_t             state;
    logic [BITSROW-1:0] cap_row;
    logic [WSW-1:0]     cap_word;
    logic [WIDTH-1:0]   cap_bw, cap_din;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            cnt      <= '0;
            cap_row  <= '0;
            cap_word <= '0;
            cap_bw   <= '0;
            cap_din  <= '0;
        end else begin
            case (state)
                IDLE: if (wr_rmw) begin
                    cap_row  <= row_of(wr_adr);
                    cap_word <= word_of(wr_adr);
                    cap_bw   <= bw;
                    cap_din  <= din;
                    cnt      <= CW'((SRAM_DELAY > 1) ? SRAM_DELAY - 2 : 0);
                    ready    <= 1'b0;
                    state    <= (SRAM_DELAY > 1) ? WAIT : WB;
                end
                WAIT: if (cnt == '0) state <= WB;
                      else cnt <= cnt - CW'(1);
                WB: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign mem_read   = wr_rmw || rd_ok;
    assign mem_rd_adr = wr_rmw ? row_of(wr_adr) : (rd_ok ? row_of(rd_adr) : '0);

    always_comb begin
        mem_write  = 1'b0;
        mem_wr_adr = '0;
        mem_din    = '0;
        if (state == WB && !rst) begin
            mem_write  = 1'b1;
            mem_wr_adr = cap_row;
            mem_din    = merge(mem_rd_dout, cap_word, cap_bw, cap_din);
        end else if (wr_hit) begin
            mem_write  = 1'b1;
            mem_wr_adr = row_of(wr_adr);
            mem_din    = hit_din;
        end
    end

    // User-read pipeline; RMW reads never enter it, so they cannot raise rd_vld.
    logic [SRAM_DELAY-1:0] pv, po;
    logic [WSW-1:0]        pw [SRAM_DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            po <= '0;
            for (int i = 0; i < SRAM_DELAY; i++) pw[i] <= '0;
        end else begin
            pv[0] <= rd_acc;
            po[0] <= rd_acc && !in_range(rd_adr);
            pw[0] <= word_of(rd_adr);
            for (int i = 1; i < SRAM_DELAY; i++) begin
                pv[i] <= pv[i-1];
                po[i] <= po[i-1];
                pw[i] <= pw[i-1];
            end
        end
    end

    logic [WIDTH-1:0] sel, dout_now;
    logic             vld_now;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUMWRDS; i++)
            if (32'(pw[SRAM_DELAY-1]) == i) sel = mem_rd_dout[i*WIDTH +: WIDTH];
    end

    assign vld_now  = pv[SRAM_DELAY-1] && !rst;
    assign dout_now = (vld_now && !po[SRAM_DELAY-1]) ? sel : '0;

    if (FLOPOUT != 0) begin : g_flop
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_vld  <= 1'b0;
                rd_dout <= '0;
            end else begin
                rd_vld  <= vld_now;
                rd_dout <= dout_now;
            end
        end
    end else begin : g_comb
        assign rd_vld  = vld_now;
        assign rd_dout = dout_now;
    end
endmodule

// File: tb/tb_align_rmw_ramwrap.sv
// Scoreboard bench for align_rmw_ramwrap: 8-bit words, 3 words per row, 48 words, 2-cycle SRAM.
// Covers the ALIGN_ROWCACHE_EN hit path when the macro is defined for the build.
module tb_align_rmw_ramwrap;
    localparam int W  = 8;
    localparam int NA = 48;
    localparam int BA = 6;
    localparam int NW = 3;
    localparam int BWW = 2;
    localparam int NS = 16;
    localparam int BS = 4;
    localparam int D  = 2;
    localparam int RW = NW * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready, write = 1'b0, read = 1'b0, rd_vld;
    logic [BA-1:0] wr_adr = '0, rd_adr = '0;
    logic [W-1:0]  bw = '0, din = '0, rd_dout;
    logic          mem_write, mem_read;
    logic [BS-1:0] mem_wr_adr, mem_rd_adr;
    logic [RW-1:0] mem_din, mem_rd_dout;

    align_rmw_ramwrap #(
        .WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .NUMWRDS(NW), .BITWRDS(BWW),
        .NUMSROW(NS), .BITSROW(BS), .SRAM_DELAY(D), .FLOPOUT(0)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .write(write), .wr_adr(wr_adr), .bw(bw), .din(din),
        .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dout(rd_dout),
        .mem_write(mem_write), .mem_wr_adr(mem_wr_adr), .mem_din(mem_din),
        .mem_read(mem_read), .mem_rd_adr(mem_rd_adr), .mem_rd_dout(mem_rd_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical SRAM: fixed read latency D, stale output filled with noise.
    logic [RW-1:0] sram [NS];
    logic [RW-1:0] rpipe [D];
    logic          sram_clr = 1'b1, poke_en = 1'b0;
    logic [BS-1:0] poke_row = '0;
    logic [RW-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (sram_clr) for (int i = 0; i < NS; i++) sram[i] <= '0;
        else if (poke_en) sram[poke_row] <= poke_data;
        else if (mem_write) sram[mem_wr_adr] <= mem_din;
        rpipe[0] <= mem_read ? sram[mem_rd_adr] : RW'($urandom);
        for (int i = 1; i < D; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rd_dout = rpipe[D-1];

    typedef struct { int cyc; logic [W-1:0] val; } exp_t;
    exp_t         sb[$];
    logic [W-1:0] model [NA];
    int           checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            chk("mem_rw_exclusive", 64'(mem_read && mem_write), 0);
            if (rd_vld) begin
                if (sb.size() == 0) chk("rd_vld_unexpected", 64'(rd_vld), 0);
                else begin
                    e = sb.pop_front();
                    chk("rd_latency_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rd_dout", 64'(rd_dout), 64'(e.val));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic w, input logic [BA-1:0] wa, input logic [W-1:0] m,
                        input logic [W-1:0] d, input logic r, input logic [BA-1:0] ra,
                        output logic wacc, output logic racc);
        @(negedge clk);
        write = w; wr_adr = wa; bw = m; din = d; read = r; rd_adr = ra;
        #1;
        wacc = w && ready;
        racc = r && ready && !w;
        if (wacc && wa < NA) model[wa] = (model[wa] & ~m) | (d & m);
        if (racc) sb.push_back('{cyc + D, (ra < NA) ? model[ra] : 8'h00});
    endtask

    task automatic idle(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, a, b);
    endtask

    task automatic wait_ready(input string name);
        logic a, b;
        for (int i = 0; i < 20 && !ready; i++) step(0, '0, '0, '0, 0, '0, a, b);
        chk(name, 64'(ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; write = 1'b0; read = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one write and check the row write it eventually produces.
    task automatic wr_expect(input string name, input logic [BA-1:0] a, input logic [W-1:0] m,
                             input logic [W-1:0] d, input logic [BS-1:0] row, input logic [RW-1:0] rowdat);
        logic wa, ra;
        step(1, a, m, d, 0, '0, wa, ra);
        chk({name, "_accept"}, 64'(wa), 1);
        for (int i = 0; i < 8 && !mem_write; i++) step(0, '0, '0, '0, 0, '0, wa, ra);
        chk({name, "_mem_write"}, 64'(mem_write), 1);
        chk({name, "_mem_wr_adr"}, 64'(mem_wr_adr), 64'(row));
        chk({name, "_mem_din"}, 64'(mem_din), 64'(rowdat));
        wait_ready({name, "_ready_back"});
    endtask

    initial begin
        logic         wa, ra, hw, hr;
        logic [BA-1:0] hwa, hra;
        logic [W-1:0]  hm, hd, old10;
        int            t;

        for (int i = 0; i < NA; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(ready), 1);
        chk("rst_rd_vld", 64'(rd_vld), 0);
        chk("rst_rd_dout", 64'(rd_dout), 0);
        chk("rst_mem_write", 64'(mem_write), 0);
        chk("rst_mem_read", 64'(mem_read), 0);
        chk("rst_mem_wr_adr", 64'(mem_wr_adr), 0);
        chk("rst_mem_rd_adr", 64'(mem_rd_adr), 0);
        chk("rst_mem_din", 64'(mem_din), 0);
        sram_clr = 1'b0;
        rst = 1'b0;

        // Full-word write, cycle-exact RMW timing.
        step(1, 6'd7, 8'hFF, 8'hA5, 0, '0, wa, ra);
        chk("t1_accept", 64'(wa), 1);
        chk("t1_mem_read_T", 64'(mem_read), 1);
        chk("t1_mem_rd_adr_T", 64'(mem_rd_adr), 2);
        step(0, '0, '0, '0, 0, '0, wa, ra);
        chk("t1_ready_T1", 64'(ready), 0);
        chk("t1_no_write_T1", 64'(mem_write), 0);
        step(0, '0, '0, '0, 0, '0, wa, ra);
        chk("t1_ready_T2", 64'(ready), 0);
        chk("t1_mem_write_T2", 64'(mem_write), 1);
        chk("t1_mem_wr_adr", 64'(mem_wr_adr), 2);
        chk("t1_mem_din", 64'(mem_din), 64'h00A500);
        step(0, '0, '0, '0, 0, '0, wa, ra);
        chk("t1_ready_T3", 64'(ready), 1);
        step(0, '0, '0, '0, 1, 6'd7, wa, ra);
        chk("t1_read_accept", 64'(ra), 1);
        idle(3);

        // Partial mask merge into a populated row.
        do_reset();
        @(negedge clk);
        poke_en = 1'b1; poke_row = 4'd2; poke_data = 24'h11A522;
        @(negedge clk);
        poke_en = 1'b0;
        model[6] = 8'h22; model[7] = 8'hA5; model[8] = 8'h11;
        wr_expect("t2", 6'd7, 8'h0F, 8'h0F, 4'd2, 24'h11AF22);

        // Write wins over a simultaneous read; read goes through once ready returns.
        step(1, 6'd3, 8'hFF, 8'h3C, 1, 6'd0, wa, ra);
        t = cyc;
        chk("t3_write_accept", 64'(wa), 1);
        chk("t3_read_stalled", 64'(ra), 0);
        chk("t3_rmw_row", 64'(mem_rd_adr), 1);
        for (int i = 0; i < 6 && !ra; i++) step(0, '0, '0, '0, 1, 6'd0, wa, ra);
        chk("t3_read_accept", 64'(ra), 1);
        chk("t3_read_accept_cycle", 64'(cyc), 64'(t + 3));
        idle(4);

        // Back-to-back reads across a row boundary.
        for (int a = 0; a < 4; a++) begin
            step(0, '0, '0, '0, 1, BA'(a), wa, ra);
            chk("t4_read_accept", 64'(ra), 1);
            chk("t4_ready_held", 64'(ready), 1);
        end
        idle(4);

        // Out-of-range accesses.
        step(1, 6'd50, 8'hFF, 8'h77, 0, '0, wa, ra);
        chk("oor_wr_accept", 64'(wa), 1);
        chk("oor_wr_no_read", 64'(mem_read), 0);
        chk("oor_wr_no_write", 64'(mem_write), 0);
        step(0, '0, '0, '0, 1, 6'd60, wa, ra);
        chk("oor_wr_ready_stays", 64'(ready), 1);
        chk("oor_rd_accept", 64'(ra), 1);
        chk("oor_rd_no_mem_read", 64'(mem_read), 0);
        idle(4);

        // Reset while the RMW sits in WAIT, with a read in flight.
        do_reset();
        step(0, '0, '0, '0, 1, 6'd1, wa, ra);
        old10 = model[10];
        step(1, 6'd10, 8'hFF, 8'hEE, 0, '0, wa, ra);
        chk("t5_write_accept", 64'(wa), 1);
        @(negedge clk);
        rst = 1'b1; write = 1'b0; read = 1'b0;
        sb.delete();
        model[10] = old10;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_ready_after_reset", 64'(ready), 1);
        for (int i = 0; i < 6; i++) begin
            step(0, '0, '0, '0, 0, '0, wa, ra);
            chk("t5_no_mem_write", 64'(mem_write), 0);
        end

`ifdef ALIGN_ROWCACHE_EN
        do_reset();
        wr_expect("t6_first", 6'd6, 8'hFF, 8'h5A, 4'd2, {model[8], model[7], 8'h5A});
        step(1, 6'd8, 8'hFF, 8'hC3, 0, '0, wa, ra);
        chk("t6_hit_accept", 64'(wa), 1);
        chk("t6_hit_mem_write", 64'(mem_write), 1);
        chk("t6_hit_no_mem_read", 64'(mem_read), 0);
        chk("t6_hit_row", 64'(mem_wr_adr), 2);
        chk("t6_hit_din", 64'(mem_din), 64'({8'hC3, model[7], 8'h5A}));
        step(0, '0, '0, '0, 0, '0, wa, ra);
        chk("t6_ready_kept", 64'(ready), 1);
`endif

        // Randomised traffic; unaccepted requests are held until taken.
        hw = 0; hr = 0; hwa = '0; hra = '0; hm = '0; hd = '0;
        for (int i = 0; i < 500; i++) begin
            if (!hw && !hr) begin
                hw  = ($urandom_range(0, 3) == 0);
                hr  = ($urandom_range(0, 1) == 1);
                hwa = BA'($urandom_range(0, 55));
                hra = BA'($urandom_range(0, 55));
                hm  = ($urandom_range(0, 1) == 1) ? 8'hFF : W'($urandom);
                hd  = W'($urandom);
            end
            step(hw, hwa, hm, hd, hr, hra, wa, ra);
            if (wa) hw = 0;
            if (ra) hr = 0;
        end
        idle(8);

        for (int a = 0; a < NA; a++)
            chk("final_sram_word", 64'(sram[a / NW][(a % NW) * W +: W]), 64'(model[a]));
        chk("scoreboard_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/align_rmw_ramwrap.md
Name: align_rmw_ramwrap

Overview:
- Maps a narrow logical word space onto a wide single-port physical SRAM row (NUMWRDS words per row).
- Targets macros with no bit-write mask: partial-row writes become a read-modify-write (RMW) sequence under a small FSM, with a ready/stall handshake.
- Generalises the aligned 1RW wrapper to any NUMWRDS (non-power-of-two included).
- Sits between the logical memory controller and the physical SRAM instance.

Parameters:
- WIDTH, 32, logical word width.
- NUMADDR, 1024, logical depth.
- BITADDR, 10, logical address width.
- NUMWRDS, 4, logical words per physical row; any value >=1.
- BITWRDS, 2, word-select width; 0 allowed when NUMWRDS=1.
- NUMSROW, 256, physical rows; must satisfy NUMSROW*NUMWRDS >= NUMADDR.
- BITSROW, 8, row address width.
- SRAM_DELAY, 2, mem_read to mem_rd_dout latency in cycles; >=1.
- FLOPOUT, 0, 1 adds an output register on rd_vld/rd_dout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  wrapper can accept a command this cycle.
- write  in  1  write request.
- wr_adr  in  BITADDR  logical write address.
- bw  in  WIDTH  per-bit write enable.
- din  in  WIDTH  write data.
- read  in  1  read request.
- rd_adr  in  BITADDR  logical read address.
- rd_vld  out  1  read data valid.
- rd_dout  out  WIDTH  read data.
- mem_write  out  1  physical row write.
- mem_wr_adr  out  BITSROW  physical write row.
- mem_din  out  NUMWRDS*WIDTH  full-row write data.
- mem_read  out  1  physical row read.
- mem_rd_adr  out  BITSROW  physical read row.
- mem_rd_dout  in  NUMWRDS*WIDTH  physical read data.

Behaviour:
- Address split: row = adr / NUMWRDS, word = adr % NUMWRDS. The word occupies row bits [word*WIDTH +: WIDTH]. Both divisions are exact integer arithmetic; NUMWRDS is not required to be a power of two.
- Handshake:
  - Write is accepted when write && ready.
  - Read is accepted when read && ready && !write; write has priority.
  - A non-accepted request must be held by the source; the wrapper keeps no record of it.
- Read path:
  - Accept at cycle T drives mem_read=1 and mem_rd_adr=row combinationally in cycle T.
  - rd_vld=1 at T+SRAM_DELAY+FLOPOUT, with rd_dout equal to the selected word of mem_rd_dout.
  - The word select is carried in a SRAM_DELAY-deep shift pipeline alongside a valid bit.
- Write FSM states: IDLE, WAIT, WB.
  - IDLE, write accepted at T: mem_read of the row in cycle T; go to WAIT; ready=0 from T+1.
  - WAIT: count SRAM_DELAY-1 cycles. The RMW read is tagged in its own pipeline and never raises rd_vld.
  - WB (cycle T+SRAM_DELAY): mem_write=1, mem_wr_adr=row, mem_din = old row with the target word replaced by (old & ~bw) | (din & bw). Other words pass through unchanged. Return to IDLE; ready=1 at T+SRAM_DELAY+1.
  - When SRAM_DELAY=1, WAIT is skipped.
  - wr_adr, bw and din are captured at accept; the inputs are don't-care afterwards.
- Ordering:
  - Reads accepted before a write return pre-write data.
  - Reads accepted after ready returns see post-write data.
  - mem_read and mem_write are never both 1 in the same cycle.
- Out of range (adr >= NUMADDR):
  - Write is accepted and dropped: no mem access, ready stays 1.
  - Read is accepted, no mem_read is issued, and rd_vld arrives with the normal latency with rd_dout=0.
- Reset:
  - Outputs: ready=1, rd_vld=0, mem_write=0, mem_read=0, rd_dout=0. Address and data outputs are 0.
  - All pipeline valid bits are cleared.
  - Reset mid-RMW returns the FSM to IDLE with no mem_write issued.
  - Reads in flight are discarded; no rd_vld follows reset.

Optional Feature:
- ALIGN_ROWCACHE_EN: single-entry row cache holding the row address, full row data and a valid bit. It is loaded on every mem_write and invalidated by reset.
  - Write in IDLE that hits the valid cached row: merge with the cached data, mem_write in the accept cycle, ready stays 1, no mem_read.
  - Misses use the normal RMW sequence.
  - Reads are unaffected.
- Without the macro, every in-range write runs the full RMW sequence.

Test Plan:
1. WIDTH=8, NUMWRDS=3, NUMADDR=48, SRAM_DELAY=2, memory preloaded with 0: write adr=7 (row 2, word 1), din=0xA5, bw=0xFF. Required:
   - mem_read at T;
   - mem_write at T+2 with mem_wr_adr=2 and mem_din=0x00A500;
   - ready low during T+1..T+2.
   - A read of adr 7 accepted afterwards returns 0xA5 after 2 cycles.
2. Partial mask: row 2 = 0x11A522, write adr=7, din=0x0F, bw=0x0F. Required: mem_din=0x11AF22.
3. Simultaneous read adr=0 and write adr=3 with ready=1. Required:
   - write accepted, read stalled;
   - read accepted at T+3;
   - rd_vld at T+5.
4. Back-to-back reads at adr 0,1,2,3 on consecutive cycles. Required: four consecutive rd_vld cycles returning the correct words, and ready held at 1.
5. Reset asserted in WAIT. Required:
   - no mem_write at any later cycle;
   - ready=1 the cycle after reset deasserts;
   - no stray rd_vld.
6. With ALIGN_ROWCACHE_EN: write adr=6, then write adr=8 (both row 2). Required:
   - the second write issues mem_write in its accept cycle with no mem_read;
   - ready never deasserts for the second write.
